// File: rtl/noc_vc_output_arbiter.sv
// Packet-granular round-robin output arbiter with wormhole lock and one registered output stage.
// Define NOC_ARB_STATS_EN to add saturating packet/stall counters (stat_pkts, stat_stalls).
module noc_vc_output_arbiter #(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned INPUTS     = 5,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned IDX_W     = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
    input  logic [INPUTS-1:0]            in_last,
    input  logic [INPUTS-1:0]            in_valid,
    output logic [INPUTS-1:0]            in_ready,
    output logic [FLIT_WIDTH-1:0]        out_flit,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic [IDX_W-1:0]             grant_idx
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]         stat_pkts,
    output logic [CNT_WIDTH-1:0]         stat_stalls
`endif
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    if (INPUTS < 1 || FLIT_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
        $error("noc_vc_output_arbiter: INPUTS, FLIT_WIDTH and CNT_WIDTH must be >= 1");
    end

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, out_valid_d;

    logic                  found;
    logic [IDX_W-1:0]      pick;
    int unsigned           cand;
    logic [FLIT_WIDTH-1:0] sel_flit;
    logic                  sel_last;
    logic                  sel_valid;
    logic                  stage_free;
    logic                  accept;

    // Scan rr_ptr+1 .. rr_ptr+INPUTS so the last winner has the lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int unsigned off = 1; off <= INPUTS; off++) begin
            cand = (32'(rr_ptr_q) + off) % INPUTS;
            if (!found && in_valid[IDX_W'(cand)]) begin
                found = 1'b1;
                pick  = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        sel_flit  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < INPUTS; i++) begin
            if (IDX_W'(i) == grant_q) begin
                sel_flit  = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
                sel_last  = in_last[i];
                sel_valid = in_valid[i];
            end
        end
    end

    assign stage_free = !out_valid_q || out_ready;

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < INPUTS; i++) begin
            in_ready[i] = (state_q == ST_LOCKED) && (IDX_W'(i) == grant_q) && stage_free;
        end
    end

    assign accept = (state_q == ST_LOCKED) && sel_valid && stage_free;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_flit_d  = out_flit_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (accept) begin
            out_flit_d  = sel_flit;
            out_last_d  = sel_last;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                if (accept && sel_last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= IDX_W'(INPUTS - 1);
            out_flit_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_flit_q  <= out_flit_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_flit  = out_flit_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_LOCKED);
    assign grant_idx = (state_q == ST_LOCKED) ? grant_q : '0;

`ifdef NOC_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] stat_pkts_q;
    logic [CNT_WIDTH-1:0] stat_stalls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts_q   <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (accept && sel_last && (stat_pkts_q != '1)) begin
                stat_pkts_q <= stat_pkts_q + 1'b1;
            end
            if (out_valid_q && !out_ready && (stat_stalls_q != '1)) begin
                stat_stalls_q <= stat_stalls_q + 1'b1;
            end
        end
    end

    assign stat_pkts   = stat_pkts_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_noc_vc_output_arbiter.sv
// Directed self-checking bench for noc_vc_output_arbiter (INPUTS=5, FLIT_WIDTH=32).
// Statistics scenario is compiled only when NOC_ARB_STATS_EN is defined.
module tb_noc_vc_output_arbiter;

    localparam int unsigned FW = 32;
    localparam int unsigned NI = 5;
`ifdef NOC_ARB_STATS_EN
    localparam int unsigned CW = 4;
`else
    localparam int unsigned CW = 16;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NI*FW-1:0] in_flit;
    logic [NI-1:0] in_last;
    logic [NI-1:0] in_valid;
    logic [NI-1:0] in_ready;
    logic [FW-1:0] out_flit;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic [2:0]    grant_idx;
`ifdef NOC_ARB_STATS_EN
    logic [CW-1:0] stat_pkts;
    logic [CW-1:0] stat_stalls;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    noc_vc_output_arbiter #(
        .FLIT_WIDTH(FW),
        .INPUTS(NI),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_flit(in_flit),
        .in_last(in_last),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_flit(out_flit),
        .out_last(out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .grant_idx(grant_idx)
`ifdef NOC_ARB_STATS_EN
        ,
        .stat_pkts(stat_pkts),
        .stat_stalls(stat_stalls)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_flit(input int i, input logic [FW-1:0] d, input logic l);
        in_flit[i*FW +: FW] = d;
        in_last[i] = l;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        in_last = '0;
        in_flit = '0;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_flit = '1;
        in_last = '1;
        in_valid = '1;
        out_ready = 1'b1;
        step();
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%0h exp=0", out_last); end
        total++; if (out_flit !== 32'h0) begin bad++; $display("FAIL rst_out_flit got=%0h exp=0", out_flit); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        total++; if (grant_idx !== 3'd0) begin bad++; $display("FAIL rst_grant got=%0h exp=0", grant_idx); end
        total++; if (in_ready !== 5'b00000) begin bad++; $display("FAIL rst_in_ready got=%0b exp=00000", in_ready); end
        rst = 1'b0;
        in_valid = '0;
        in_last = '0;
        in_flit = '0;
    endtask

    task automatic test_single_request();
        set_flit(2, 32'hA1, 1'b0);
        in_valid = 5'b00100;
        settle();
        total++; if (in_ready !== 5'b00000) begin bad++; $display("FAIL t1_idle_ready got=%0b exp=00000", in_ready); end
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%0h exp=1", busy); end
        total++; if (grant_idx !== 3'd2) begin bad++; $display("FAIL t1_grant got=%0d exp=2", grant_idx); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t1_c1_valid got=%0h exp=0", out_valid); end
        total++; if (in_ready !== 5'b00100) begin bad++; $display("FAIL t1_ready got=%0b exp=00100", in_ready); end
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'hA1 || out_last !== 1'b0) begin bad++; $display("FAIL t1_f1 got=%0h/%0h/%0h exp=1/a1/0", out_valid, out_flit, out_last); end
        set_flit(2, 32'hA2, 1'b0);
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'hA2 || out_last !== 1'b0) begin bad++; $display("FAIL t1_f2 got=%0h/%0h/%0h exp=1/a2/0", out_valid, out_flit, out_last); end
        set_flit(2, 32'hA3, 1'b1);
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'hA3 || out_last !== 1'b1) begin bad++; $display("FAIL t1_f3 got=%0h/%0h/%0h exp=1/a3/1", out_valid, out_flit, out_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_end got=%0h exp=0", busy); end
        total++; if (grant_idx !== 3'd0) begin bad++; $display("FAIL t1_grant_idle got=%0d exp=0", grant_idx); end
        in_valid = '0;
        in_last = '0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t1_drain got=%0h exp=0", out_valid); end
    endtask

    task automatic test_fairness();
        int ord [6] = '{0, 1, 4, 0, 1, 4};
        do_reset();
        set_flit(0, 32'h100, 1'b1);
        set_flit(1, 32'h101, 1'b1);
        set_flit(4, 32'h104, 1'b1);
        in_valid = 5'b10011;
        for (int k = 0; k < 6; k++) begin
            step();
            total++; if (busy !== 1'b1 || grant_idx !== 3'(ord[k])) begin bad++; $display("FAIL t2_grant%0d got=%0h/%0d exp=1/%0d", k, busy, grant_idx, ord[k]); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t2_gap%0d got=%0h exp=0", k, out_valid); end
            step();
            total++; if (out_valid !== 1'b1 || out_flit !== 32'(32'h100 + ord[k])) begin bad++; $display("FAIL t2_flit%0d got=%0h/%0h exp=1/%0h", k, out_valid, out_flit, 32'h100 + ord[k]); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_idle%0d got=%0h exp=0", k, busy); end
        end
        in_valid = '0;
        step();
    endtask

    task automatic test_lock_backpressure();
        do_reset();
        set_flit(3, 32'h31, 1'b0);
        in_valid = 5'b01000;
        step();
        total++; if (grant_idx !== 3'd3 || busy !== 1'b1) begin bad++; $display("FAIL t3_grant got=%0d/%0h exp=3/1", grant_idx, busy); end
        set_flit(0, 32'h0F, 1'b1);
        in_valid = 5'b01001;
        settle();
        total++; if (in_ready !== 5'b01000) begin bad++; $display("FAIL t3_ready got=%0b exp=01000", in_ready); end
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'h31) begin bad++; $display("FAIL t3_f1 got=%0h/%0h exp=1/31", out_valid, out_flit); end
        set_flit(3, 32'h32, 1'b0);
        out_ready = 1'b0;
        settle();
        total++; if (in_ready !== 5'b00000) begin bad++; $display("FAIL t3_stall_ready got=%0b exp=00000", in_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (out_valid !== 1'b1 || out_flit !== 32'h31 || busy !== 1'b1 || grant_idx !== 3'd3) begin bad++; $display("FAIL t3_hold%0d got=%0h/%0h/%0h/%0d exp=1/31/1/3", k, out_valid, out_flit, busy, grant_idx); end
            total++; if (in_ready !== 5'b00000) begin bad++; $display("FAIL t3_hold_ready%0d got=%0b exp=00000", k, in_ready); end
        end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'h32) begin bad++; $display("FAIL t3_f2 got=%0h/%0h exp=1/32", out_valid, out_flit); end
        set_flit(3, 32'h33, 1'b0);
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'h33) begin bad++; $display("FAIL t3_f3 got=%0h/%0h exp=1/33", out_valid, out_flit); end
        set_flit(3, 32'h34, 1'b1);
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'h34 || out_last !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL t3_f4 got=%0h/%0h/%0h/%0h exp=1/34/1/0", out_valid, out_flit, out_last, busy); end
        in_valid = 5'b00001;
        step();
        total++; if (grant_idx !== 3'd0 || busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL t3_next_grant got=%0d/%0h/%0h exp=0/1/0", grant_idx, busy, out_valid); end
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'h0F) begin bad++; $display("FAIL t3_in0 got=%0h/%0h exp=1/f", out_valid, out_flit); end
        in_valid = '0;
        step();
    endtask

    task automatic test_bubble();
        do_reset();
        set_flit(1, 32'hB1, 1'b0);
        set_flit(2, 32'h2F, 1'b1);
        in_valid = 5'b00110;
        step();
        total++; if (grant_idx !== 3'd1) begin bad++; $display("FAIL t4_grant got=%0d exp=1", grant_idx); end
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'hB1) begin bad++; $display("FAIL t4_f1 got=%0h/%0h exp=1/b1", out_valid, out_flit); end
        in_valid = 5'b00100;
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if (out_valid !== 1'b0 || busy !== 1'b1 || grant_idx !== 3'd1) begin bad++; $display("FAIL t4_gap%0d got=%0h/%0h/%0d exp=0/1/1", k, out_valid, busy, grant_idx); end
            total++; if (in_ready[2] !== 1'b0) begin bad++; $display("FAIL t4_wait%0d got=%0h exp=0", k, in_ready[2]); end
        end
        set_flit(1, 32'hB2, 1'b1);
        in_valid = 5'b00110;
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'hB2 || out_last !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL t4_f2 got=%0h/%0h/%0h/%0h exp=1/b2/1/0", out_valid, out_flit, out_last, busy); end
        in_valid = 5'b00100;
        step();
        total++; if (grant_idx !== 3'd2 || busy !== 1'b1) begin bad++; $display("FAIL t4_grant2 got=%0d/%0h exp=2/1", grant_idx, busy); end
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'h2F) begin bad++; $display("FAIL t4_in2 got=%0h/%0h exp=1/2f", out_valid, out_flit); end
        in_valid = '0;
        step();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        set_flit(0, 32'hE1, 1'b0);
        in_valid = 5'b00001;
        step();
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'hE1) begin bad++; $display("FAIL t5_f1 got=%0h/%0h exp=1/e1", out_valid, out_flit); end
        set_flit(0, 32'hE2, 1'b0);
        rst = 1'b1;
        step();
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || grant_idx !== 3'd0) begin bad++; $display("FAIL t5_after_rst got=%0h/%0h/%0d exp=0/0/0", out_valid, busy, grant_idx); end
        rst = 1'b0;
        set_flit(0, 32'h51, 1'b1);
        set_flit(1, 32'h61, 1'b1);
        in_valid = 5'b00011;
        settle();
        total++; if (in_ready !== 5'b00000) begin bad++; $display("FAIL t5_idle_ready got=%0b exp=00000", in_ready); end
        step();
        total++; if (grant_idx !== 3'd0 || busy !== 1'b1) begin bad++; $display("FAIL t5_grant0 got=%0d/%0h exp=0/1", grant_idx, busy); end
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'h51) begin bad++; $display("FAIL t5_in0 got=%0h/%0h exp=1/51", out_valid, out_flit); end
        in_valid = 5'b00010;
        step();
        total++; if (grant_idx !== 3'd1 || busy !== 1'b1) begin bad++; $display("FAIL t5_grant1 got=%0d/%0h exp=1/1", grant_idx, busy); end
        step();
        total++; if (out_valid !== 1'b1 || out_flit !== 32'h61) begin bad++; $display("FAIL t5_in1 got=%0h/%0h exp=1/61", out_valid, out_flit); end
        in_valid = '0;
        step();
    endtask

`ifdef NOC_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        total++; if (stat_pkts !== 4'd0 || stat_stalls !== 4'd0) begin bad++; $display("FAIL t6_reset got=%0d/%0d exp=0/0", stat_pkts, stat_stalls); end
        set_flit(0, 32'h77, 1'b1);
        in_valid = 5'b00001;
        for (int k = 0; k < 40; k++) step();
        in_valid = '0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t6_last_out got=%0h exp=1", out_valid); end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        out_ready = 1'b1;
        step();
        total++; if (stat_pkts !== 4'd15) begin bad++; $display("FAIL t6_pkts got=%0d exp=15", stat_pkts); end
        total++; if (stat_stalls !== 4'd5) begin bad++; $display("FAIL t6_stalls got=%0d exp=5", stat_stalls); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_flit = '0;
        in_last = '0;
        in_valid = '0;
        out_ready = 1'b1;
        test_reset();
        test_single_request();
        test_fairness();
        test_lock_backpressure();
        test_bubble();
        test_reset_mid_packet();
`ifdef NOC_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
